// File: rtl/char_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module      : char_pixel_streamer
// Description : Fetches a 5x7 glyph from the character ROM and streams it as
//               GRB colour words, column by column, over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module char_pixel_streamer #(
    parameter int COLS       = 5,
    parameter int ROWS       = 7,
    parameter bit SERPENTINE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           char_code,
    input  logic                 char_valid,
    output logic                 char_ready,
    input  logic [23:0]          fg_color,
    input  logic [23:0]          bg_color,
    input  logic                 flush,
    output logic [6:0]           rom_addr,
    input  logic [COLS*ROWS-1:0] rom_data,
    output logic [23:0]          pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_last,
    output logic                 char_done,
    output logic                 busy
);

    localparam int c_bits = COLS * ROWS;
    localparam int c_idxw = $clog2(c_bits);
    localparam int c_cw   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_rw   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [6:0]          r_rom_addr;
    logic [c_bits-1:0]   r_bitmap;
    logic [23:0]         r_fg;
    logic [23:0]         r_bg;
    logic [c_cw-1:0]     r_col;
    logic [c_rw-1:0]     r_row;
    logic                r_char_done;

    logic                w_accept;
    logic                w_fire;
    logic                w_row_end;
    logic                w_col_end;
    logic                w_done_next;
    logic [c_rw-1:0]     w_row_eff;
    logic [c_idxw-1:0]   w_lin;
    logic [c_idxw-1:0]   w_bit;

    // A code presented together with flush is not taken: flush wins.
    assign char_ready = (r_state == ST_IDLE) && !flush;
    assign w_accept   = char_valid && char_ready;
    assign pix_valid  = (r_state == ST_STREAM);
    assign busy       = (r_state != ST_IDLE);
    assign w_fire     = pix_valid && pix_ready;
    assign w_row_end  = (r_row == c_rw'(ROWS - 1));
    assign w_col_end  = (r_col == c_cw'(COLS - 1));
    assign pix_last   = pix_valid && w_row_end && w_col_end;
    assign char_done  = r_char_done;
    assign rom_addr   = r_rom_addr;

    // Odd columns run bottom-to-top when serpentine wiring is selected.
    always_comb begin
        w_row_eff = r_row;
        if (SERPENTINE && r_col[0]) begin
            w_row_eff = c_rw'(ROWS - 1) - r_row;
        end
        w_lin    = c_idxw'(w_row_eff) * c_idxw'(COLS) + c_idxw'(r_col);
        w_bit    = c_idxw'(c_bits - 1) - w_lin;
        pix_data = r_bitmap[w_bit] ? r_fg : r_bg;
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    w_state_next = ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_fire && w_row_end && w_col_end) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rom_addr  <= '0;
            r_bitmap    <= '0;
            r_fg        <= '0;
            r_bg        <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_char_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_char_done <= w_done_next;
            if (flush) begin
                r_col <= '0;
                r_row <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_rom_addr <= char_code;
                            r_fg       <= fg_color;
                            r_bg       <= bg_color;
                            r_col      <= '0;
                            r_row      <= '0;
                        end
                    end
                    ST_FETCH: begin
                        r_bitmap <= rom_data;
                    end
                    ST_STREAM: begin
                        if (w_fire) begin
                            if (w_row_end) begin
                                r_row <= '0;
                                r_col <= w_col_end ? '0 : r_col + c_cw'(1);
                            end else begin
                                r_row <= r_row + c_rw'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_char_pixel_streamer.sv
`default_nettype none
// Testbench for char_pixel_streamer: serpentine and plain instances driven in
// lockstep, checked against a column-major glyph model.
module tb_char_pixel_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  char_code;
    logic        char_valid;
    logic [23:0] fg_color, bg_color;
    logic        flush;
    logic        pix_ready;

    logic        char_ready1, pix_valid1, pix_last1, char_done1, busy1;
    logic [6:0]  rom_addr1;
    logic [34:0] rom_data1;
    logic [23:0] pix_data1;
    logic        char_ready0, pix_valid0, pix_last0, char_done0, busy0;
    logic [6:0]  rom_addr0;
    logic [34:0] rom_data0;
    logic [23:0] pix_data0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] last_w1[$];
    logic [23:0] last_w0[$];

    always #5 clk = ~clk;

    function automatic logic [34:0] font(input logic [6:0] code);
        if (code < 7'd32)  return 35'd0;
        if (code == 7'h41) return 35'b01110_10001_10001_11111_10001_10001_10001;
        if (code == 7'h42) return 35'b11110_10001_10001_11110_10001_10001_11110;
        return {code, ~code, code, ~code, code} ^ 35'h5A5A5A5A5;
    endfunction

    assign rom_data1 = font(rom_addr1);
    assign rom_data0 = font(rom_addr0);

    char_pixel_streamer #(.COLS(5), .ROWS(7), .SERPENTINE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .char_code(char_code), .char_valid(char_valid),
        .char_ready(char_ready1), .fg_color(fg_color), .bg_color(bg_color),
        .flush(flush), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .pix_data(pix_data1), .pix_valid(pix_valid1), .pix_ready(pix_ready),
        .pix_last(pix_last1), .char_done(char_done1), .busy(busy1)
    );

    char_pixel_streamer #(.COLS(5), .ROWS(7), .SERPENTINE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .char_code(char_code), .char_valid(char_valid),
        .char_ready(char_ready0), .fg_color(fg_color), .bg_color(bg_color),
        .flush(flush), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .pix_data(pix_data0), .pix_valid(pix_valid0), .pix_ready(pix_ready),
        .pix_last(pix_last0), .char_done(char_done0), .busy(busy0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Word k of the glyph: column k/7, k-th pixel down (or up on odd serpentine columns).
    function automatic logic [23:0] model_word(input logic [6:0] code, input logic [23:0] fg,
                                               input logic [23:0] bg, input bit serp, input int k);
        logic [34:0] bm;
        int c, j, r;
        bm = font(code);
        c  = k / 7;
        j  = k % 7;
        r  = (serp && (c % 2 == 1)) ? 6 - j : j;
        return bm[34 - (r * 5 + c)] ? fg : bg;
    endfunction

    // Starts and ends at a negedge. flush_at/rst_at: abort once that many words were accepted.
    task automatic run_char(input logic [6:0] code, input logic [23:0] fg, input logic [23:0] bg,
                            input bit rnd, input int flush_at, input int rst_at,
                            output int first_v, output int done_c);
        bit stalled;
        logic [23:0] held1, held0;
        logic held_last;
        int bad1, bad0;
        last_w1.delete();
        last_w0.delete();
        first_v = -1;
        done_c  = -1;
        stalled = 1'b0;
        held1 = '0; held0 = '0; held_last = 1'b0;
        char_code  = code;
        fg_color   = fg;
        bg_color   = bg;
        char_valid = 1'b1;
        pix_ready  = 1'b1;
        chk("char_ready_idle", {char_ready1, char_ready0}, 2'b11);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            char_valid = 1'b0;
            char_code  = 7'($urandom);
            fg_color   = 24'($urandom);
            bg_color   = 24'($urandom);
            if (stalled) begin
                chk("hold_valid", {pix_valid1, pix_valid0}, 2'b11);
                chk("hold_data_s", pix_data1, held1);
                chk("hold_data_p", pix_data0, held0);
                chk("hold_last", pix_last1, held_last);
            end
            if (pix_valid1 && first_v < 0) first_v = c;
            if (char_done1) begin
                done_c = c;
                chk("ready_at_done", char_ready1, 1'b1);
                chk("done_both", char_done0, 1'b1);
                break;
            end
            if (pix_valid1) chk("pix_last", pix_last1, last_w1.size() == 34);
            if (flush_at >= 0 && pix_valid1 && last_w1.size() == flush_at) begin
                flush     = 1'b1;
                pix_ready = 1'b0;
                @(negedge clk);
                flush = 1'b0;
                chk("flush_valid", {pix_valid1, pix_valid0}, 2'b00);
                chk("flush_busy", {busy1, busy0}, 2'b00);
                chk("flush_done", char_done1, 1'b0);
                @(negedge clk);
                chk("flush_no_done", {char_done1, char_done0}, 2'b00);
                return;
            end
            if (rst_at >= 0 && pix_valid1 && last_w1.size() == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("arst_outs", {pix_valid1, pix_last1, char_done1, busy1, char_ready1}, 5'b00001);
                chk("arst_addr", rom_addr1, 7'd0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("arst_release", {char_ready1, busy1, char_done1}, 3'b100);
                return;
            end
            pix_ready = rnd ? 1'($urandom) : 1'b1;
            if (pix_valid1 && pix_ready) last_w1.push_back(pix_data1);
            if (pix_valid0 && pix_ready) last_w0.push_back(pix_data0);
            stalled   = pix_valid1 && !pix_ready;
            held1     = pix_data1;
            held0     = pix_data0;
            held_last = pix_last1;
        end
        chk("done_seen", done_c >= 0, 1'b1);
        chk("word_count_s", last_w1.size(), 35);
        chk("word_count_p", last_w0.size(), 35);
        bad1 = 0;
        bad0 = 0;
        for (int k = 0; k < last_w1.size(); k++)
            if (last_w1[k] !== model_word(code, fg, bg, 1'b1, k)) bad1++;
        for (int k = 0; k < last_w0.size(); k++)
            if (last_w0[k] !== model_word(code, fg, bg, 1'b0, k)) bad0++;
        chk("words_serp", bad1, 0);
        chk("words_plain", bad0, 0);
    endtask

    typedef struct {
        logic [6:0]  code;
        logic [23:0] fg;
        logic [23:0] bg;
        bit          rnd;
        bit          allbg;
        int          exp_first;
        int          exp_done;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int fv, dc, nbg;
        tbl[0] = '{7'h41, 24'h00FF00, 24'h000000, 1'b0, 1'b0, 2, 37};
        tbl[1] = '{7'h41, 24'h00FF00, 24'h000000, 1'b1, 1'b0, 2, -1};
        tbl[2] = '{7'h10, 24'hABCDEF, 24'h101010, 1'b0, 1'b1, 2, 37};
        tbl[3] = '{7'h42, 24'h123456, 24'h654321, 1'b0, 1'b0, 2, 37};
        tbl[4] = '{7'h7E, 24'hFFFFFF, 24'h0000AA, 1'b1, 1'b0, 2, -1};

        rst_n = 1'b0; char_code = '0; char_valid = 1'b0; fg_color = '0; bg_color = '0;
        flush = 1'b0; pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {pix_valid1, pix_last1, char_done1, busy1, char_ready1}, 5'b00001);
        chk("reset_addr", rom_addr1, 7'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_char(tbl[i].code, tbl[i].fg, tbl[i].bg, tbl[i].rnd, -1, -1, fv, dc);
            chk("first_valid", fv, tbl[i].exp_first);
            if (tbl[i].exp_done >= 0) chk("done_cycle", dc, tbl[i].exp_done);
            if (tbl[i].allbg) begin
                nbg = 0;
                foreach (last_w1[k]) if (last_w1[k] !== tbl[i].bg) nbg++;
                chk("all_bg", nbg, 0);
            end
        end

        // Hand-derived 'A' words: column 0 is 0,1,1,1,1,1,1; column 1 rows 0..6 is 1,0,0,1,0,0,0.
        run_char(7'h41, 24'h00FF00, 24'h000000, 1'b0, -1, -1, fv, dc);
        chk("A_w0", last_w1[0], 24'h000000);
        chk("A_w1", last_w1[1], 24'h00FF00);
        chk("A_serp_w7", last_w1[7], 24'h000000);
        chk("A_serp_w10", last_w1[10], 24'h00FF00);
        chk("A_serp_w13", last_w1[13], 24'h00FF00);
        chk("A_plain_w7", last_w0[7], 24'h00FF00);
        chk("A_plain_w13", last_w0[13], 24'h000000);

        // Flush during word 12, then a full 'B'.
        run_char(7'h41, 24'h00FF00, 24'h000000, 1'b0, 11, -1, fv, dc);
        run_char(7'h42, 24'h00FF00, 24'h000000, 1'b0, -1, -1, fv, dc);
        chk("after_flush_first", fv, 2);
        chk("after_flush_done", dc, 37);

        // Async reset during word 20, then a full character.
        run_char(7'h41, 24'h00FF00, 24'h000000, 1'b1, -1, 19, fv, dc);
        run_char(7'h41, 24'h00FF00, 24'h000000, 1'b0, -1, -1, fv, dc);
        chk("after_rst_done", dc, 37);

        for (int i = 0; i < 10; i++) begin
            run_char(7'($urandom_range(0, 127)), 24'($urandom), 24'($urandom), 1'b1, -1, -1, fv, dc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
